// File: rtl/serial_byte_feeder.sv
// Parallel-to-serial feeder: buffers bytes in a small FIFO and shifts each one out
// MSB-first with shift_enable, pulsing byte_done when the downstream register holds it.
module serial_byte_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              data,
  output logic                              shift_enable,
  output logic                              byte_done,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sbuf_q, sbuf_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  data_q, data_d;
  logic                  se_q, se_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head, shifted;

  // in_ready looks only at the registered count, never at a same-cycle pop
  assign in_ready     = reset && (count_q < DEPTH);
  assign push         = in_valid && in_ready;
  assign head         = mem_q[rd_ptr_q];
  assign shifted      = sbuf_q << 1;

  assign data         = data_q;
  assign shift_enable = se_q;
  assign byte_done    = done_q;
  assign busy         = busy_q;
  assign fifo_count   = count_q;

  always_comb begin
    pop       = 1'b0;
    state_d   = state_q;
    sbuf_d    = sbuf_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = 1'b0;
    se_d      = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          sbuf_d    = head;
          bit_cnt_d = '0;
          state_d   = SHIFT;
          se_d      = 1'b1;
          data_d    = head[DATA_WIDTH-1];
        end
      end
      SHIFT: begin
        sbuf_d    = shifted;
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        se_d      = 1'b1;
        data_d    = shifted[DATA_WIDTH-1];
        if (bit_cnt_q == LAST_BIT) begin
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
            se_d      = 1'b0;
            data_d    = 1'b0;
          end else if (count_q != '0) begin
            // back-to-back: next byte's MSB lines up with byte_done
            pop       = 1'b1;
            sbuf_d    = head;
            bit_cnt_d = '0;
            data_d    = head[DATA_WIDTH-1];
          end else begin
            state_d = IDLE;
            se_d    = 1'b0;
            data_d  = 1'b0;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == LAST_GAP) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    busy_d   = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q    <= 1'b0;
      se_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      se_q      <= se_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Byte storage carries no reset; validity is tracked by the pointers and state
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
    sbuf_q <= sbuf_d;
  end

endmodule
